// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction-fetch and data-memory ports.
// Define ARB_RR_EN for round-robin arbitration (default: fixed DM > IF).
module mem_port_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_ack,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          grant_id
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_ACK   = 2'd3;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    logic [1:0] state;
    logic [3:0] cnt;
    logic       pick_dm;

`ifdef ARB_RR_EN
    logic last_grant;

    // On a tie the port that did not win last time goes first.
    always_comb begin
        pick_dm = dm_req && (!if_req || !last_grant);
    end
`else
    always_comb begin
        pick_dm = dm_req;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            grant_id  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
`ifdef ARB_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (if_req || dm_req) begin
                        grant_id <= pick_dm;
                        mem_addr <= pick_dm ? dm_addr : if_addr;
                        mem_we   <= pick_dm && dm_we;
                        if (pick_dm) begin
                            mem_wdata <= dm_wdata;
                        end
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (mem_we) begin
                        state <= S_ACK;
                    end else begin
                        cnt   <= LAT;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        if (grant_id) begin
                            dm_rdata <= mem_rdata;
                        end else begin
                            if_rdata <= mem_rdata;
                        end
                        state <= S_ACK;
                    end
                end
                S_ACK: begin
`ifdef ARB_RR_EN
                    last_grant <= grant_id;
`endif
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_en = (state == S_ISSUE);
        busy   = (state != S_IDLE);
        if_ack = (state == S_ACK) && !grant_id;
        dm_ack = (state == S_ACK) && grant_id;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-timing model plus directed checks.
// Also exercises a MEM_LAT=3 instance for long-latency read timing.
module tb_mem_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int L  = 1;
    localparam int L3 = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [AW-1:0] if_addr = '0, dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic          if_ack, dm_ack, mem_en, mem_we, busy, grant_id;
    logic [DW-1:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    logic          dm_req3 = 1'b0;
    logic          if_ack3, dm_ack3, mem_en3, mem_we3, busy3, grant_id3;
    logic [DW-1:0] if_rdata3, dm_rdata3, mem_wdata3, mem_rdata3;
    logic [AW-1:0] mem_addr3;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(L)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr),
        .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .grant_id(grant_id)
    );

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(L3)) u3 (
        .clk(clk), .reset(reset),
        .if_req(1'b0), .if_addr(8'h00),
        .if_ack(if_ack3), .if_rdata(if_rdata3),
        .dm_req(dm_req3), .dm_we(1'b0), .dm_addr(8'h40),
        .dm_wdata(32'h0), .dm_ack(dm_ack3), .dm_rdata(dm_rdata3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
        .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3),
        .busy(busy3), .grant_id(grant_id3)
    );

    int total = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h at %0t",
                      nm, act, exp, $time);
    endtask

    function automatic logic [31:0] init_val(input logic [7:0] a);
        return (a == 8'h10) ? 32'hDEADBEEF : {24'hA5A5A5, a};
    endfunction

    // Memory with MEM_LAT read latency; garbage outside the valid cycle.
    logic [31:0] bmem [256];
    bit          written [256];
    logic [31:0] rd_q = '0;
    int          rd_cnt = 0;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                bmem[mem_addr]    <= mem_wdata;
                written[mem_addr] <= 1'b1;
            end else begin
                rd_q   <= written[mem_addr] ? bmem[mem_addr]
                                            : init_val(mem_addr);
                rd_cnt <= 1;
            end
        end else if (rd_cnt != 0) begin
            rd_cnt <= (rd_cnt == L) ? 0 : rd_cnt + 1;
        end
    end
    assign mem_rdata = (rd_cnt == L) ? rd_q : 32'hBAD0BAD0;

    int rd3 = 0;
    always @(posedge clk) begin
        if (mem_en3 && !mem_we3) rd3 <= 1;
        else if (rd3 != 0) rd3 <= (rd3 == L3) ? 0 : rd3 + 1;
    end
    assign mem_rdata3 = (rd3 == L3) ? 32'hCAFEF00D : 32'hBAD0BAD0;

    // Transaction model: a winner sampled in idle cycle t0 strobes at
    // t0+1 and acks at t0+2 (+L for reads); idle again after the ack.
    logic [31:0] refm [256];
    bit          refw [256];
    int          cyc = 0, t0 = 0, ack_at = 0;
    bit          m_busy = 0, m_win = 0, m_we = 0, m_last = 1, fin;
    logic [7:0]  m_addr = '0;
    logic [31:0] m_wdata = '0, m_if_rd = '0, m_dm_rd = '0, rd_new;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (!reset) begin
            chk("rst busy", busy, 0);
            chk("rst mem_en", mem_en, 0);
            chk("rst if_ack", if_ack, 0);
            chk("rst dm_ack", dm_ack, 0);
            chk("rst mem_we", mem_we, 0);
            chk("rst mem_addr", mem_addr, 0);
            chk("rst mem_wdata", mem_wdata, 0);
            chk("rst if_rdata", if_rdata, 0);
            chk("rst dm_rdata", dm_rdata, 0);
            chk("rst grant_id", grant_id, 0);
            m_busy = 0; m_we = 0; m_addr = '0; m_wdata = '0;
            m_if_rd = '0; m_dm_rd = '0; m_last = 1;
        end else begin
            rd_new = refw[m_addr] ? refm[m_addr] : init_val(m_addr);
            fin = m_busy && (cyc == ack_at);
            chk("m busy", busy, m_busy);
            if (m_busy) chk("m grant_id", grant_id, m_win);
            chk("m mem_en", mem_en, m_busy && (cyc == t0 + 1));
            chk("m mem_we", mem_we, m_we);
            chk("m mem_addr", mem_addr, m_addr);
            chk("m mem_wdata", mem_wdata, m_wdata);
            chk("m if_ack", if_ack, fin && !m_win);
            chk("m dm_ack", dm_ack, fin && m_win);
            chk("m if_rdata", if_rdata,
                (fin && !m_win && !m_we) ? rd_new : m_if_rd);
            chk("m dm_rdata", dm_rdata,
                (fin && m_win && !m_we) ? rd_new : m_dm_rd);
            if (fin) begin
                if (!m_we) begin
                    if (m_win) m_dm_rd = rd_new;
                    else m_if_rd = rd_new;
                end
                m_last = m_win;
                m_busy = 0;
            end else if (!m_busy && (if_req || dm_req)) begin
`ifdef ARB_RR_EN
                m_win = (if_req && dm_req) ? !m_last : dm_req;
`else
                m_win = dm_req;
`endif
                m_busy = 1;
                t0 = cyc;
                m_addr = m_win ? dm_addr : if_addr;
                m_we = m_win && dm_we;
                if (m_win) m_wdata = dm_wdata;
                if (m_we) begin
                    refm[m_addr] = m_wdata;
                    refw[m_addr] = 1;
                end
                ack_at = cyc + 2 + (m_we ? 0 : L);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    int order [4] = '{9, 9, 9, 9};
    int n, guard, k, first, second, seen;

    initial begin
        repeat (3) @(negedge clk);
        chk("init busy", busy, 0);
        chk("init mem_en", mem_en, 0);
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);

        // IF read of 0x10
        #1 if_req = 1'b1; if_addr = 8'h10;
        @(negedge clk);
        chk("ifrd T ack", if_ack, 0);
        @(negedge clk);
        chk("ifrd T+1 mem_en", mem_en, 1);
        chk("ifrd T+1 mem_addr", mem_addr, 8'h10);
        chk("ifrd T+1 mem_we", mem_we, 0);
        @(negedge clk);
        chk("ifrd T+2 ack", if_ack, 0);
        @(negedge clk);
        chk("ifrd T+3 ack", if_ack, 1);
        chk("ifrd rdata", if_rdata, 32'hDEADBEEF);
        chk("ifrd dm_ack", dm_ack, 0);
        @(posedge clk); #1 if_req = 1'b0;

        // DM write of 0x55 to 0x20
        @(posedge clk);
        #1 dm_req = 1'b1; dm_we = 1'b1; dm_addr = 8'h20; dm_wdata = 32'h55;
        @(negedge clk);
        @(negedge clk);
        chk("dmwr mem_en", mem_en, 1);
        chk("dmwr mem_we", mem_we, 1);
        chk("dmwr mem_addr", mem_addr, 8'h20);
        chk("dmwr mem_wdata", mem_wdata, 32'h55);
        @(negedge clk);
        chk("dmwr ack", dm_ack, 1);
        chk("dmwr mem_en off", mem_en, 0);
        chk("dmwr dm_rdata", dm_rdata, 0);
        @(posedge clk); #1 dm_req = 1'b0; dm_we = 1'b0;

        // Both ports requesting continuously
        @(posedge clk);
        #1 if_req = 1'b1; if_addr = 8'h30; dm_req = 1'b1; dm_addr = 8'h20;
        n = 0; guard = 0;
        while (n < 4 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (if_ack) begin order[n] = 0; n++; end
            else if (dm_ack) begin order[n] = 1; n++; end
        end
        @(posedge clk); #1 if_req = 1'b0; dm_req = 1'b0;
        chk("both ack count", n, 4);
`ifdef ARB_RR_EN
        chk("rr order0", order[0], 0);
        chk("rr order1", order[1], 1);
        chk("rr order2", order[2], 0);
        chk("rr order3", order[3], 1);
        chk("rr if_rdata", if_rdata, 32'hA5A5A530);
`else
        chk("fixed order0", order[0], 1);
        chk("fixed order1", order[1], 1);
        chk("fixed order2", order[2], 1);
        chk("fixed order3", order[3], 1);
`endif
        chk("both dm_rdata", dm_rdata, 32'h55);

        // Back-to-back IF reads
        @(posedge clk);
        #1 if_req = 1'b1; if_addr = 8'h44;
        k = 0; first = -1; second = -1;
        while (second < 0 && k < 100) begin
            @(negedge clk);
            k++;
            if (mem_en) begin
                if (first < 0) first = k;
                else second = k;
            end
        end
        chk("b2b spacing", second - first, 4);
        @(negedge clk);
        @(negedge clk);
        chk("b2b second ack", if_ack, 1);
        chk("b2b rdata", if_rdata, 32'hA5A5A544);
        @(posedge clk); #1 if_req = 1'b0;

        // MEM_LAT=3 DM read on the second instance
        @(posedge clk); #1 dm_req3 = 1'b1;
        @(negedge clk);
        chk("lat3 T busy", busy3, 0);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk("lat3 busy", busy3, 1);
            chk("lat3 grant_id", grant_id3, 1);
            chk("lat3 dm_ack", dm_ack3, (i == 5) ? 1 : 0);
        end
        chk("lat3 rdata", dm_rdata3, 32'hCAFEF00D);
        @(posedge clk); #1 dm_req3 = 1'b0;
        @(negedge clk);
        chk("lat3 idle", busy3, 0);

        // Reset during the WAIT of an IF read
        @(posedge clk); #1 if_req = 1'b1; if_addr = 8'h10;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("abort busy", busy, 0);
        chk("abort mem_en", mem_en, 0);
        chk("abort if_ack", if_ack, 0);
        chk("abort if_rdata", if_rdata, 0);
        chk("abort mem_addr", mem_addr, 0);
        chk("abort grant_id", grant_id, 0);
        if_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("abort no ack", if_ack, 0);
        end
        @(posedge clk); #1 reset = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_en || busy) seen++;
        end
        chk("post-reset quiet", seen, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one single-port synchronous memory between the processor's instruction-fetch (IF) port and data-memory (DM) port.
- Sequences each access: grant, issue, wait for memory latency, acknowledge.
- Sits between the processor core and its memory inside the processor+memory top.
- One transaction in flight at a time; outstanding requests are held off until acknowledged.

Parameters:
- AW, 8, address width in bits.
- DW, 32, data width in bits.
- MEM_LAT, 1, memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- if_req  in  1  IF read request; held high with if_addr stable until if_ack.
- if_addr  in  AW  IF read address.
- if_ack  out  1  one-cycle pulse; if_rdata valid in the same cycle.
- if_rdata  out  DW  registered IF read data; holds its value until the next IF read ack.
- dm_req  in  1  DM request; held high with dm_we/dm_addr/dm_wdata stable until dm_ack.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  AW  DM address.
- dm_wdata  in  DW  DM write data.
- dm_ack  out  1  one-cycle pulse completing a DM transaction.
- dm_rdata  out  DW  registered DM read data; updated only on a DM read ack.
- mem_en  out  1  memory access strobe; exactly one cycle per transaction.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  AW  memory address; registered.
- mem_wdata  out  DW  memory write data; registered.
- mem_rdata  in  DW  memory read data; valid MEM_LAT cycles after the mem_en cycle.
- busy  out  1  high in every state except IDLE.
- grant_id  out  1  0 = IF, 1 = DM; valid while busy.

Behaviour:
- Reset values: all outputs 0, state IDLE, wait counter 0, last_grant = DM.
- State machine:
  - IDLE: sample requests.
    - If any request is present, pick the winner, latch its command onto mem_addr/mem_we/mem_wdata and set grant_id → ISSUE.
    - With no request, remain in IDLE.
  - ISSUE: mem_en = 1 for this one cycle.
    - Write → ACK.
    - Read → WAIT, load counter with MEM_LAT.
  - WAIT: decrement the counter.
    - When the counter reaches 1, capture mem_rdata into the granted port's rdata register → ACK.
    - When MEM_LAT = 1, WAIT lasts exactly one cycle.
  - ACK: pulse the granted port's ack for one cycle; update last_grant → IDLE.
- Latency, measured from the IDLE sampling cycle T:
  - Write: ack at T+2.
  - Read: ack at T+2+MEM_LAT.
  - Minimum spacing between transactions: 3 cycles for writes, 3+MEM_LAT cycles for reads.
- A requester keeping req high after its ack is treated as a new request at the next IDLE cycle.
- Priority without the optional feature: fixed, DM over IF; IF can be starved.
- A lone requester always wins, whichever arbitration mode is compiled.
- mem_we, mem_addr and mem_wdata hold their values between transactions; mem_en = 0 outside ISSUE.
- Request changes during ISSUE/WAIT/ACK are ignored; the latched command is used.
- Dropping req before the IDLE sample means no access occurs.
- Reset asserted mid-transaction:
  - Immediately abort to IDLE and clear all outputs.
  - The transaction in flight is not acknowledged.
  - A write already strobed is not retracted.
- Counter width is 4 bits.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin arbitration. On simultaneous IF and DM requests, the port not in last_grant wins. last_grant resets to DM, so IF wins the first tie.
- Undefined: fixed priority DM > IF; last_grant is unused and may be optimised away.

Test Plan:
- Reset: drive reset = 0 during the WAIT of a read → all outputs 0 immediately, no ack; after reset = 1 with no requests, mem_en stays 0 for 10 cycles.
- IF read, MEM_LAT = 1, if_addr = 8'h10, mem_rdata = 32'hDEADBEEF → mem_en = 1, mem_addr = 8'h10 at T+1; if_ack at T+3 with if_rdata = 32'hDEADBEEF; dm_ack stays 0.
- DM write, dm_addr = 8'h20, dm_wdata = 32'h55 → mem_en = mem_we = 1 for one cycle at T+1 with matching addr/data; dm_ack at T+2; dm_rdata unchanged.
- Both requests held high for 4 transactions, macro undefined → 4 consecutive dm_acks, no if_ack; macro defined → ack order IF, DM, IF, DM.
- MEM_LAT = 3 DM read → dm_ack exactly at T+5; busy high T+1..T+5; grant_id = 1 throughout.
- Back-to-back IF reads with req kept high → second mem_en exactly 4 cycles after the first (MEM_LAT = 1).
